// File: rtl/wb_queue_pkg.sv
// Shared types and constants for the writeback queue.
// An entry is one pending register-file write: destination plus full 64-bit data.
package wb_queue_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int WB_DATA_W  = 64;

  localparam logic [REG_ADDR_W-1:0] HILO_ADDR = 6'd32;
  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = 6'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0]  wdata;
  } entry_t;

endpackage

// File: rtl/wb_queue.sv
// In-order writeback queue: accepts up to two results per cycle, buffers them
// in a circular array and retires up to two per cycle onto registered write ports.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in0_valid,
  input  logic [REG_ADDR_W-1:0]      in0_waddr,
  input  logic [WB_DATA_W-1:0]       in0_wdata,
  input  logic                       in1_valid,
  input  logic [REG_ADDR_W-1:0]      in1_waddr,
  input  logic [WB_DATA_W-1:0]       in1_wdata,
  output logic                       in_ready,
  input  logic                       wb_stall,
  output logic                       we0,
  output logic [REG_ADDR_W-1:0]      waddr0,
  output logic [WB_DATA_W-1:0]       wdata0,
  output logic                       we1,
  output logic [REG_ADDR_W-1:0]      waddr1,
  output logic [WB_DATA_W-1:0]       wdata1,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_we0;
  logic            r_we1;
  entry_t          r_port0;
  entry_t          r_port1;

  logic            w_acc0;
  logic            w_acc1;
  entry_t          w_in [2];
  entry_t          w_cand [4];
  int              w_buf;
  int              w_nin;
  int              w_ret;
  int              w_pop;
  int              w_skip;
  int              w_nstore;

  assign in_ready = (r_count <= CW'(DEPTH - 2));

  // Candidates are the two oldest buffered entries followed by the compacted
  // accepted inputs; the first two retire, the unretired inputs go to the tail.
  always_comb begin
    w_acc0   = in_ready && in0_valid && (in0_waddr != ZERO_ADDR);
    w_acc1   = in_ready && in1_valid && (in1_waddr != ZERO_ADDR);
    w_in[0]  = '{waddr: in0_waddr, wdata: in0_wdata};
    w_in[1]  = '{waddr: in1_waddr, wdata: in1_wdata};
    w_nin    = int'(w_acc0) + int'(w_acc1);
    if (!w_acc0) w_in[0] = w_in[1];
    w_buf    = (r_count >= CW'(2)) ? 2 : int'(r_count);
    for (int i = 0; i < 4; i++) begin
      w_cand[i] = '0;
      if (i < w_buf) begin
        w_cand[i] = r_mem[r_head + PW'(i)];
      end else if ((i - w_buf) < w_nin) begin
        w_cand[i] = w_in[(i - w_buf) & 1];
      end
    end
    w_ret = 0;
    w_pop = 0;
    if (!wb_stall) begin
      w_ret = ((w_buf + w_nin) > 2) ? 2 : (w_buf + w_nin);
      w_pop = w_buf;
    end
    w_skip   = w_ret - w_pop;
    w_nstore = w_nin - w_skip;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_we0   <= 1'b0;
      r_we1   <= 1'b0;
      r_port0 <= '0;
      r_port1 <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_nstore);
      r_count <= r_count - CW'(w_pop) + CW'(w_nstore);
      r_we0   <= (w_ret >= 1);
      r_we1   <= (w_ret >= 2);
      if (w_ret >= 1) r_port0 <= w_cand[0];
      if (w_ret >= 2) r_port1 <= w_cand[1];
    end
  end

  // Storage needs no reset: count alone says which slots hold live entries.
  always_ff @(posedge clk) begin
    if (w_nstore >= 1) r_mem[r_tail] <= w_in[w_skip & 1];
    if (w_nstore >= 2) r_mem[r_tail + PW'(1)] <= w_in[1];
  end

  assign we0    = r_we0;
  assign waddr0 = r_port0.waddr;
  assign wdata0 = r_port0.wdata;
  assign we1    = r_we1;
  assign waddr1 = r_port1.waddr;
  assign wdata1 = r_port1.wdata;
  assign count  = r_count;

endmodule

// File: tb/tb_wb_queue.sv
// Directed-vector bench for wb_queue: each scenario task drives inputs and
// compares registered outputs against hand-computed values.
module tb_wb_queue;
  import wb_queue_pkg::*;

  logic        clk;
  logic        resetn;
  logic        in0_valid;
  logic [5:0]  in0_waddr;
  logic [63:0] in0_wdata;
  logic        in1_valid;
  logic [5:0]  in1_waddr;
  logic [63:0] in1_wdata;
  logic        in_ready;
  logic        wb_stall;
  logic        we0;
  logic [5:0]  waddr0;
  logic [63:0] wdata0;
  logic        we1;
  logic [5:0]  waddr1;
  logic [63:0] wdata1;
  logic [3:0]  count;

  int vectors;
  int miscompares;

  wb_queue #(.DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .in0_valid(in0_valid), .in0_waddr(in0_waddr), .in0_wdata(in0_wdata),
    .in1_valid(in1_valid), .in1_waddr(in1_waddr), .in1_wdata(in1_wdata),
    .in_ready(in_ready), .wb_stall(wb_stall),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    in0_valid = 1'b0; in0_waddr = '0; in0_wdata = '0;
    in1_valid = 1'b0; in1_waddr = '0; in1_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; wb_stall = 1'b0;
    idle_inputs();
    #12;
    vectors++; if (we0 !== 1'b0 || we1 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we got %b%b want 00", we0, we1); end
    vectors++; if (waddr0 !== 6'd0 || wdata0 !== 64'd0 || waddr1 !== 6'd0 || wdata1 !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_ports got %0d/%h %0d/%h want zeros", waddr0, wdata0, waddr1, wdata1); end
    vectors++; if (count !== 4'd0 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_count got %0d rdy %b want 0 rdy 1", count, in_ready); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single();
    in0_valid = 1'b1; in0_waddr = 6'd5; in0_wdata = 64'h1234;
    tick();
    idle_inputs();
    vectors++; if (we0 !== 1'b1 || waddr0 !== 6'd5 || wdata0 !== 64'h1234) begin miscompares++; $display("[TB] FAIL single_p0 got %b/%0d/%h want 1/5/1234", we0, waddr0, wdata0); end
    vectors++; if (we1 !== 1'b0 || count !== 4'd0) begin miscompares++; $display("[TB] FAIL single_p1 got we1 %b count %0d want 0/0", we1, count); end
    tick();
    vectors++; if (we0 !== 1'b0 || waddr0 !== 6'd5) begin miscompares++; $display("[TB] FAIL single_idle got %b/%0d want 0/5", we0, waddr0); end
  endtask

  task automatic test_filter();
    in0_valid = 1'b1; in0_waddr = 6'd0; in0_wdata = 64'h55;
    in1_valid = 1'b1; in1_waddr = 6'd7; in1_wdata = 64'hAA;
    tick();
    idle_inputs();
    vectors++; if (we0 !== 1'b1 || waddr0 !== 6'd7 || wdata0 !== 64'hAA) begin miscompares++; $display("[TB] FAIL filter_p0 got %b/%0d/%h want 1/7/aa", we0, waddr0, wdata0); end
    vectors++; if (we1 !== 1'b0 || count !== 4'd0) begin miscompares++; $display("[TB] FAIL filter_p1 got we1 %b count %0d want 0/0", we1, count); end
  endtask

  task automatic test_stall_drain();
    wb_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_ready_pre%0d got %b want 1", k, in_ready); end
      in0_valid = 1'b1; in0_waddr = 6'(2*k+1); in0_wdata = 64'h100 + 64'(2*k+1);
      in1_valid = 1'b1; in1_waddr = 6'(2*k+2); in1_wdata = 64'h100 + 64'(2*k+2);
      tick();
      vectors++; if (count !== 4'(2*k+2) || we0 !== 1'b0 || we1 !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_fill%0d got count %0d we %b%b want %0d 00", k, count, we0, we1, 2*k+2); end
    end
    vectors++; if (in_ready !== 1'b0 || waddr0 !== 6'd7) begin miscompares++; $display("[TB] FAIL stall_full got rdy %b waddr0 %0d want 0/7", in_ready, waddr0); end
    in0_valid = 1'b1; in0_waddr = 6'd20; in0_wdata = 64'hBAD;
    in1_valid = 1'b1; in1_waddr = 6'd21; in1_wdata = 64'hBAD;
    tick();
    vectors++; if (count !== 4'd8) begin miscompares++; $display("[TB] FAIL stall_blocked got count %0d want 8", count); end
    idle_inputs();
    wb_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (we0 !== 1'b1 || waddr0 !== 6'(2*k+1) || wdata0 !== 64'h100 + 64'(2*k+1)) begin miscompares++; $display("[TB] FAIL drain%0d_p0 got %b/%0d/%h want 1/%0d", k, we0, waddr0, wdata0, 2*k+1); end
      vectors++; if (we1 !== 1'b1 || waddr1 !== 6'(2*k+2) || wdata1 !== 64'h100 + 64'(2*k+2)) begin miscompares++; $display("[TB] FAIL drain%0d_p1 got %b/%0d/%h want 1/%0d", k, we1, waddr1, wdata1, 2*k+2); end
      vectors++; if (count !== 4'(6-2*k)) begin miscompares++; $display("[TB] FAIL drain%0d_count got %0d want %0d", k, count, 6-2*k); end
    end
    tick();
    vectors++; if (we0 !== 1'b0 || we1 !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_done got we %b%b rdy %b want 00 1", we0, we1, in_ready); end
  endtask

  task automatic test_mixed();
    wb_stall = 1'b1;
    in0_valid = 1'b1; in0_waddr = 6'd10; in0_wdata = 64'hA0;
    tick();
    wb_stall = 1'b0;
    in0_valid = 1'b1; in0_waddr = 6'd11; in0_wdata = 64'hB0;
    in1_valid = 1'b1; in1_waddr = 6'd12; in1_wdata = 64'hC0;
    tick();
    idle_inputs();
    vectors++; if (we0 !== 1'b1 || waddr0 !== 6'd10 || we1 !== 1'b1 || waddr1 !== 6'd11 || count !== 4'd1) begin miscompares++; $display("[TB] FAIL mixed_first got %b/%0d %b/%0d count %0d want 1/10 1/11 1", we0, waddr0, we1, waddr1, count); end
    tick();
    vectors++; if (we0 !== 1'b1 || waddr0 !== 6'd12 || wdata0 !== 64'hC0 || we1 !== 1'b0 || count !== 4'd0) begin miscompares++; $display("[TB] FAIL mixed_second got %b/%0d/%h we1 %b count %0d want 1/12/c0 0 0", we0, waddr0, wdata0, we1, count); end
  endtask

  task automatic test_same_dest();
    in0_valid = 1'b1; in0_waddr = 6'd9; in0_wdata = 64'h11;
    in1_valid = 1'b1; in1_waddr = 6'd9; in1_wdata = 64'h22;
    tick();
    idle_inputs();
    vectors++; if (we0 !== 1'b1 || we1 !== 1'b1 || waddr0 !== 6'd9 || waddr1 !== 6'd9) begin miscompares++; $display("[TB] FAIL same_addr got %b/%0d %b/%0d want 1/9 1/9", we0, waddr0, we1, waddr1); end
    vectors++; if (wdata0 !== 64'h11 || wdata1 !== 64'h22) begin miscompares++; $display("[TB] FAIL same_data got %h %h want 11 22", wdata0, wdata1); end
  endtask

  task automatic test_hilo();
    in0_valid = 1'b1; in0_waddr = HILO_ADDR; in0_wdata = 64'hDEADBEEF_00C0FFEE;
    tick();
    idle_inputs();
    vectors++; if (we0 !== 1'b1 || waddr0 !== 6'd32 || wdata0 !== 64'hDEADBEEF_00C0FFEE) begin miscompares++; $display("[TB] FAIL hilo got %b/%0d/%h want 1/32/deadbeef00c0ffee", we0, waddr0, wdata0); end
  endtask

  task automatic test_async_reset();
    wb_stall = 1'b1;
    in0_valid = 1'b1; in0_waddr = 6'd13; in0_wdata = 64'h13;
    in1_valid = 1'b1; in1_waddr = 6'd14; in1_wdata = 64'h14;
    tick();
    tick();
    in1_valid = 1'b0;
    tick();
    idle_inputs();
    vectors++; if (count !== 4'd5) begin miscompares++; $display("[TB] FAIL areset_pre got count %0d want 5", count); end
    #2;
    resetn = 1'b0;
    #1;
    vectors++; if (we0 !== 1'b0 || we1 !== 1'b0 || waddr0 !== 6'd0 || wdata0 !== 64'd0 || waddr1 !== 6'd0 || wdata1 !== 64'd0) begin miscompares++; $display("[TB] FAIL areset_ports got %b/%0d/%h %b/%0d/%h want zeros", we0, waddr0, wdata0, we1, waddr1, wdata1); end
    vectors++; if (count !== 4'd0 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_count got %0d rdy %b want 0/1", count, in_ready); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    wb_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (we0 !== 1'b0 || we1 !== 1'b0 || count !== 4'd0) begin miscompares++; $display("[TB] FAIL areset_after%0d got we %b%b count %0d want 00 0", k, we0, we1, count); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_filter();
    test_stall_drain();
    test_mixed();
    test_same_dest();
    test_hilo();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
